mouse_tx: RTL and testbench

- UART transmitter that serializes one mouse report (three button flags, signed X/Y deltas) into a fixed 4-byte packet on a single TX line.
- It is the sending end of the link that mouse_rx decodes in the paint design.
- Used by the stimulus/host-side board and by loopback benches to drive mouse_rx.
- Line format is 8N1, LSB first, idle high.

---
 rtl/mouse_tx.sv | 180 ++++++++++++++++++
 tb/tb_mouse_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mouse_tx.sv
// mouse_tx: 8N1 UART transmitter sending one mouse report as a fixed A5/buttons/dx/dy packet.
// Optional macro MOUSE_TX_CHECKSUM_EN appends a fifth byte B1^B2^B3 to every packet.
module mouse_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_middle,
  input  logic [7:0] delta_x,
  input  logic [7:0] delta_y,
  output logic       tx_pin,
  output logic       busy,
  output logic       done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef MOUSE_TX_CHECKSUM_EN
  localparam int NUM_BYTES = 5;
  localparam int IDX_W     = 3;
`else
  localparam int NUM_BYTES = 4;
  localparam int IDX_W     = 2;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    baud_cnt;
  logic [CW-1:0]    baud_next;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_next;
  logic [2:0]       bit_inc;
  logic [IDX_W-1:0] byte_idx;
  logic [IDX_W-1:0] byte_next;
  logic             tx_next;
  logic             done_next;
  logic             bit_end;
  logic             accept;
  logic             last_byte;

  logic [2:0]       btn_q;
  logic [7:0]       dx_q;
  logic [7:0]       dy_q;
  logic [7:0]       cur_byte;

  assign bit_end   = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign accept    = (state == IDLE) && send;
  assign bit_inc   = bit_idx + 3'd1;
  assign last_byte = (byte_idx == IDX_W'(NUM_BYTES - 1));

  // Report fields are frozen at accept so later input changes cannot corrupt a packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= 3'b000;
      dx_q  <= 8'h00;
      dy_q  <= 8'h00;
    end else if (accept) begin
      btn_q <= {btn_middle, btn_right, btn_left};
      dx_q  <= delta_x;
      dy_q  <= delta_y;
    end
  end

  always_comb begin
    cur_byte = 8'hA5;
    case (byte_idx)
      IDX_W'(1): cur_byte = {5'b00000, btn_q};
      IDX_W'(2): cur_byte = dx_q;
      IDX_W'(3): cur_byte = dy_q;
`ifdef MOUSE_TX_CHECKSUM_EN
      IDX_W'(4): cur_byte = {5'b00000, btn_q} ^ dx_q ^ dy_q;
`endif
      default:   cur_byte = 8'hA5;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= '0;
      tx_pin   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      byte_idx <= byte_next;
      tx_pin   <= tx_next;
      busy     <= (state_next != IDLE);
      done     <= done_next;
    end
  end

  // tx_next is the line level for the cycle after this edge, so the pin itself is a plain flop.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    byte_next  = byte_idx;
    tx_next    = tx_pin;
    done_next  = 1'b0;

    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (send) begin
          state_next = START;
          baud_next  = '0;
          bit_next   = 3'd0;
          byte_next  = '0;
          tx_next    = 1'b0;
        end
      end

      START: begin
        if (bit_end) begin
          state_next = DATA;
          baud_next  = '0;
          bit_next   = 3'd0;
          tx_next    = cur_byte[0];
        end else begin
          baud_next = baud_cnt + CW'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_next = bit_inc;
            tx_next  = cur_byte[bit_inc];
          end
        end else begin
          baud_next = baud_cnt + CW'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          baud_next = '0;
          if (last_byte) begin
            state_next = IDLE;
            tx_next    = 1'b1;
            done_next  = 1'b1;
          end else begin
            state_next = START;
            byte_next  = byte_idx + IDX_W'(1);
            tx_next    = 1'b0;
          end
        end else begin
          baud_next = baud_cnt + CW'(1);
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mouse_tx.sv
// tb_mouse_tx: self-checking bench for mouse_tx at 10 clocks per bit with a line-decoding scoreboard.
// Honours MOUSE_TX_CHECKSUM_EN to expect the optional fifth byte.
module tb_mouse_tx;

  localparam int CPB = 10;
`ifdef MOUSE_TX_CHECKSUM_EN
  localparam int NBYTES = 5;
`else
  localparam int NBYTES = 4;
`endif
  localparam int PKT_CYCLES = 10 * CPB * NBYTES;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_middle = 1'b0;
  logic [7:0] delta_x = 8'h00;
  logic [7:0] delta_y = 8'h00;
  logic       tx_pin;
  logic       busy;
  logic       done;

  mouse_tx #(.CLK_FREQ(1000000), .BAUD(100000)) dut (
    .clk(clk), .rst(rst), .send(send),
    .btn_left(btn_left), .btn_right(btn_right), .btn_middle(btn_middle),
    .delta_x(delta_x), .delta_y(delta_y),
    .tx_pin(tx_pin), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       l;
    logic       r;
    logic       m;
    logic [7:0] dx;
    logic [7:0] dy;
  } vec_t;

  int         check_cnt = 0;
  int         pass_cnt = 0;
  int         reset_gen = 0;
  int         done_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Count done pulses away from the active edge
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Line decoder: finds each start bit, samples mid-bit, compares against the expected byte queue
  initial begin : monitor
    int         gen;
    logic [7:0] b;
    logic       stop_bit;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx_pin === 1'b0) begin
        gen = reset_gen;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx_pin;
        end
        repeat (CPB) @(negedge clk);
        stop_bit = tx_pin;
        if (gen == reset_gen) begin
          checkOutput("stop_bit", {31'd0, stop_bit}, 32'd1);
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_byte", {24'd0, b}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            checkOutput("line_byte", {24'd0, b}, {24'd0, e});
          end
        end
      end
    end
  end

  // Drive one report at the current negedge; the accepting posedge follows
  task automatic applyStimulus(input vec_t v, input bit expect_accept);
    logic [7:0] b1;
    btn_left   = v.l;
    btn_right  = v.r;
    btn_middle = v.m;
    delta_x    = v.dx;
    delta_y    = v.dy;
    send       = 1'b1;
    @(posedge clk);
    if (expect_accept) begin
      b1 = {5'b00000, v.m, v.r, v.l};
      exp_q.push_back(8'hA5);
      exp_q.push_back(b1);
      exp_q.push_back(v.dx);
      exp_q.push_back(v.dy);
`ifdef MOUSE_TX_CHECKSUM_EN
      exp_q.push_back(b1 ^ v.dx ^ v.dy);
`endif
    end
    @(negedge clk);
    send = 1'b0;
  endtask

  // Measure remaining busy time, then require a single-cycle done
  task automatic waitPacket(input string name, input int exp_busy);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    checkOutput({name, "_busy_len"}, n, exp_busy);
    checkOutput({name, "_done_hi"}, {31'd0, done}, 32'd1);
    @(negedge clk);
    checkOutput({name, "_done_lo"}, {31'd0, done}, 32'd0);
  endtask

  vec_t vecs[4];
  vec_t v;
  int   d0;
  int   n;

  initial begin
    vecs[0] = '{l: 1'b1, r: 1'b0, m: 1'b1, dx: 8'h05, dy: 8'hFB};
    vecs[1] = '{l: 1'b0, r: 1'b1, m: 1'b0, dx: 8'h80, dy: 8'h7F};
    vecs[2] = '{l: 1'b1, r: 1'b1, m: 1'b1, dx: 8'hFF, dy: 8'h00};
    vecs[3] = '{l: 1'b0, r: 1'b0, m: 1'b0, dx: 8'h00, dy: 8'h80};

    // Reset state and idle line
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", {31'd0, tx_pin}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_pin !== 1'b1) n++;
    end
    checkOutput("idle_low_cycles", n, 0);

    // Table-driven packets
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i], 1'b1);
      checkOutput("start_tx_low", {31'd0, tx_pin}, 32'd0);
      waitPacket("pkt", PKT_CYCLES);
      repeat (20) @(negedge clk);
    end

    // Inputs changed after accept must not reach the line
    applyStimulus(vecs[0], 1'b1);
    repeat (50) @(negedge clk);
    delta_x = 8'h7F;
    waitPacket("stable", PKT_CYCLES - 50);
    repeat (20) @(negedge clk);

    // Second send while busy is dropped
    d0 = done_cnt;
    applyStimulus(vecs[1], 1'b1);
    repeat (148) @(negedge clk);
    applyStimulus(vecs[2], 1'b0);
    repeat (PKT_CYCLES + 200) @(negedge clk);
    checkOutput("drop_done_count", done_cnt - d0, 1);
    checkOutput("drop_busy_idle", {31'd0, busy}, 32'd0);

    // Back-to-back: send in the done cycle
    applyStimulus(vecs[3], 1'b1);
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    checkOutput("b2b_first_len", n, PKT_CYCLES);
    checkOutput("b2b_done_tx_high", {31'd0, tx_pin}, 32'd1);
    applyStimulus(vecs[0], 1'b1);
    checkOutput("b2b_start_tx_low", {31'd0, tx_pin}, 32'd0);
    checkOutput("b2b_busy", {31'd0, busy}, 32'd1);
    waitPacket("b2b", PKT_CYCLES);
    repeat (20) @(negedge clk);

    // Asynchronous reset mid-packet, then a clean packet
    applyStimulus(vecs[2], 1'b1);
    repeat (122) @(negedge clk);
    #2;
    reset_gen++;
    exp_q.delete();
    rst = 1'b1;
    #1;
    checkOutput("abort_tx", {31'd0, tx_pin}, 32'd1);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    checkOutput("abort_idle_tx", {31'd0, tx_pin}, 32'd1);
    v = '{l: 1'b0, r: 1'b1, m: 1'b1, dx: 8'h3C, dy: 8'hC3};
    applyStimulus(v, 1'b1);
    waitPacket("after_rst", PKT_CYCLES);
    repeat (20) @(negedge clk);

    checkOutput("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
